// File: rtl/char_stream_writer_if.sv
// Character stream input and data-memory write port of char_stream_writer.
//
// Stream handshake: the producer holds in_valid high with in_data stable.
// A byte is consumed on a rising edge where in_valid and in_ready are both 1.
// in_ready does not depend on in_valid. in_data is ignored while in_valid is 0.
// The memory side has no handshake: every cycle with we=1 is one byte store
// of data_in at address.
interface char_stream_writer_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        we;
    logic [31:0] address;
    logic [7:0]  data_in;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  we,
        input  address,
        input  data_in
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output we,
        output address,
        output data_in
    );
endinterface

// File: rtl/char_stream_writer.sv
// Character stream writer. This block turns a byte stream into writes to a
// COLS x ROWS text screen memory. It handles newline and backspace. A clear
// request blanks every cell with spaces. The block never reads the memory.
module char_stream_writer #(
    parameter int COLS = 80,
    parameter int ROWS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    char_stream_writer_if.slave  bus,
    input  logic                 clear,
    output logic [9:0]           cursor,
    output logic                 busy,
    output logic [1:0]           state_dbg
);
    localparam int         DEPTH     = COLS * ROWS;
    localparam logic [9:0] COLS_C    = 10'(COLS);
    localparam logic [9:0] LAST_CELL = 10'(DEPTH - 1);
    localparam logic [9:0] LAST_LINE = 10'(DEPTH - COLS);
    localparam logic [7:0] SPACE     = 8'h20;
    localparam logic [7:0] NEWLINE   = 8'h0A;
    localparam logic [7:0] BACKSPACE = 8'h08;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [9:0] cursor_q, cursor_d;
    // In WRITE this is the target cell. In CLEAR it is the sweep position.
    logic [9:0] cell_q, cell_d;
    logic [7:0] wdata_q, wdata_d;
    logic       we_q, we_d;
    // Set when the pending WRITE is a printable byte and not a backspace blank.
    logic       adv_q, adv_d;
    // Keeps in_ready low until the first clock edge after reset is released.
    logic       ready_en_q;

    logic       accept;
    logic       printable;
    logic [9:0] line_start;
    logic [9:0] next_line;
    logic [9:0] cursor_inc;

    assign accept     = bus.in_valid & bus.in_ready;
    assign printable  = (bus.in_data >= 8'h20) && (bus.in_data <= 8'h7E);
    assign line_start = cursor_q - (cursor_q % COLS_C);
    assign next_line  = (line_start >= LAST_LINE) ? '0 : line_start + COLS_C;
    assign cursor_inc = (cursor_q == LAST_CELL) ? '0 : cursor_q + 10'd1;

    assign bus.in_ready = ready_en_q & (state_q == IDLE) & ~clear;
    assign bus.we       = we_q;
    assign bus.address  = {20'b0, cell_q, 2'b00};
    assign bus.data_in  = wdata_q;
    assign cursor       = cursor_q;
    assign busy         = (state_q == CLEAR);
    assign state_dbg    = state_q;

    // Enable input acceptance one edge after reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_en_q <= 1'b0;
        else        ready_en_q <= 1'b1;
    end

    // State register and registered memory-port outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cursor_q <= '0;
            cell_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            adv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            cell_q   <= cell_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            adv_q    <= adv_d;
        end
    end

    // Next-state, cursor and write-port decisions.
    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        cell_d   = cell_q;
        wdata_d  = wdata_q;
        we_d     = 1'b0;
        adv_d    = adv_q;
        unique case (state_q)
            IDLE: begin
                if (clear) begin
                    state_d  = CLEAR;
                    we_d     = 1'b1;
                    cell_d   = '0;
                    wdata_d  = SPACE;
                    cursor_d = '0;
                end else if (accept) begin
                    if (printable) begin
                        state_d = WRITE;
                        we_d    = 1'b1;
                        cell_d  = cursor_q;
                        wdata_d = bus.in_data;
                        adv_d   = 1'b1;
                    end else if (bus.in_data == NEWLINE) begin
                        cursor_d = next_line;
                    end else if (bus.in_data == BACKSPACE && cursor_q != '0) begin
                        state_d  = WRITE;
                        we_d     = 1'b1;
                        cursor_d = cursor_q - 10'd1;
                        cell_d   = cursor_q - 10'd1;
                        wdata_d  = SPACE;
                        adv_d    = 1'b0;
                    end
                    // All other bytes are consumed without any effect.
                end
            end
            WRITE: begin
                if (adv_q) cursor_d = cursor_inc;
                if (clear) begin
                    state_d  = CLEAR;
                    we_d     = 1'b1;
                    cell_d   = '0;
                    wdata_d  = SPACE;
                    cursor_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                // A clear request that arrives during the sweep has no effect.
                wdata_d = SPACE;
                if (cell_q == LAST_CELL) begin
                    state_d  = IDLE;
                    cursor_d = '0;
                end else begin
                    we_d   = 1'b1;
                    cell_d = cell_q + 10'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_char_stream_writer.sv
// Bench for char_stream_writer. A screen model turns the bytes sent into an
// expected list of memory writes and an expected cursor position.
module tb_char_stream_writer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic [9:0] cursor;
  logic       busy;
  logic [1:0] state_dbg;

  char_stream_writer_if bus();

  char_stream_writer #(.COLS(80), .ROWS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .clear     (clear),
    .cursor    (cursor),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  logic [39:0] exp_q[$];
  logic [39:0] act_q[$];
  int mcur;
  int n_checks;
  int n_fail;

  // Every write strobe seen is recorded as {address, data}.
  always @(negedge clk)
    if (rst_n === 1'b1 && bus.we === 1'b1) act_q.push_back({bus.address, bus.data_in});

  // Screen model: only the cursor and the writes that each byte causes.
  function automatic void model_apply(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      exp_q.push_back({32'(4 * mcur), b});
      mcur = (mcur + 1) % 640;
    end else if (b == 8'h0A) begin
      mcur = (((mcur / 80) + 1) * 80) % 640;
    end else if (b == 8'h08 && mcur > 0) begin
      mcur = mcur - 1;
      exp_q.push_back({32'(4 * mcur), 8'h20});
    end
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0; clear = 1'b0; bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    act_q.delete(); exp_q.delete(); mcur = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = b;
    for (int n = 0; n < 2000 && !got; n++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) got = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL send_timeout: byte %h not accepted, want accepted", b);
    end else begin
      model_apply(b);
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks += 7;
    if (bus.we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", bus.we); end
    if (bus.address !== 32'h0) begin n_fail++; $display("FAIL reset_address: got %h want 0", bus.address); end
    if (bus.data_in !== 8'h0) begin n_fail++; $display("FAIL reset_data_in: got %h want 0", bus.data_in); end
    if (cursor !== 10'd0) begin n_fail++; $display("FAIL reset_cursor: got %0d want 0", cursor); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want idle", state_dbg); end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL ready_before_edge: got %b want 0", bus.in_ready); end
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_edge: got %b want 1", bus.in_ready); end
    @(posedge clk); #1;
    act_q.delete(); exp_q.delete(); mcur = 0;
  endtask

  task automatic test_basic();
    logic [39:0] a, e;
    apply_reset();
    send_byte(8'h41);
    send_byte(8'h42);
    n_checks += 2;
    if (cursor !== 10'd2) begin n_fail++; $display("FAIL basic_cursor: got %0d want 2", cursor); end
    if (act_q.size() != 2) begin n_fail++; $display("FAIL basic_count: got %0d want 2", act_q.size()); end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front(); n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL basic_write: got %h/%h want %h/%h", a[39:8], a[7:0], e[39:8], e[7:0]); end
    end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_newline();
    logic [39:0] a, e;
    apply_reset();
    for (int i = 0; i < 5; i++) send_byte(8'(67 + i));
    act_q.delete(); exp_q.delete();
    send_byte(8'h0A);
    n_checks += 2;
    if (act_q.size() != 0) begin n_fail++; $display("FAIL newline_nowrite: got %0d writes want 0", act_q.size()); end
    if (cursor !== 10'd80) begin n_fail++; $display("FAIL newline_cursor: got %0d want 80", cursor); end
    send_byte(8'h5A);
    n_checks++;
    if (exp_q.size() != 1 || exp_q[0] !== {32'h140, 8'h5A}) begin n_fail++; $display("FAIL newline_model: model expectation disagrees with 0x140"); end
    n_checks++;
    if (act_q.size() != exp_q.size()) begin n_fail++; $display("FAIL newline_count: got %0d want %0d", act_q.size(), exp_q.size()); end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front(); n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL newline_write: got %h/%h want %h/%h", a[39:8], a[7:0], e[39:8], e[7:0]); end
    end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_backspace();
    logic [39:0] a, e;
    apply_reset();
    for (int i = 0; i < 3; i++) send_byte(8'(97 + i));
    act_q.delete(); exp_q.delete();
    send_byte(8'h08);
    n_checks += 2;
    if (cursor !== 10'd2) begin n_fail++; $display("FAIL bs_cursor: got %0d want 2", cursor); end
    if (act_q.size() != 1 || act_q[0] !== {32'h008, 8'h20}) begin n_fail++; $display("FAIL bs_write: got %0d writes, want one 0x20 at 0x008", act_q.size()); end
    act_q.delete(); exp_q.delete();
    send_byte(8'h08);
    send_byte(8'h08);
    n_checks++;
    if (act_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bs_count: got %0d want %0d", act_q.size(), exp_q.size()); end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front(); n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL bs_chain_write: got %h/%h want %h/%h", a[39:8], a[7:0], e[39:8], e[7:0]); end
    end
    act_q.delete(); exp_q.delete();
    send_byte(8'h08);
    n_checks += 2;
    if (act_q.size() != 0) begin n_fail++; $display("FAIL bs_zero_nowrite: got %0d writes want 0", act_q.size()); end
    if (cursor !== 10'd0) begin n_fail++; $display("FAIL bs_zero_cursor: got %0d want 0", cursor); end
  endtask

  task automatic test_wrap();
    logic [39:0] a, e;
    apply_reset();
    for (int i = 0; i < 7; i++) send_byte(8'h0A);
    for (int i = 0; i < 79; i++) send_byte(8'($urandom_range(32, 126)));
    n_checks++;
    if (cursor !== 10'd639) begin n_fail++; $display("FAIL wrap_setup: got %0d want 639", cursor); end
    act_q.delete(); exp_q.delete();
    send_byte(8'h78);
    n_checks += 2;
    if (act_q.size() != 1 || act_q[0] !== {32'h9FC, 8'h78}) begin n_fail++; $display("FAIL wrap_write: got %0d writes, want one 0x78 at 0x9FC", act_q.size()); end
    if (cursor !== 10'd0) begin n_fail++; $display("FAIL wrap_cursor: got %0d want 0", cursor); end
    act_q.delete(); exp_q.delete();
    for (int i = 0; i < 7; i++) send_byte(8'h0A);
    for (int i = 0; i < 40; i++) send_byte(8'($urandom_range(32, 126)));
    n_checks++;
    if (act_q.size() != exp_q.size()) begin n_fail++; $display("FAIL wrap_fill_count: got %0d want %0d", act_q.size(), exp_q.size()); end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front(); n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL wrap_fill_write: got %h/%h want %h/%h", a[39:8], a[7:0], e[39:8], e[7:0]); end
    end
    act_q.delete(); exp_q.delete();
    n_checks++;
    if (cursor !== 10'd600) begin n_fail++; $display("FAIL wrap_nl_setup: got %0d want 600", cursor); end
    send_byte(8'h0A);
    n_checks++;
    if (cursor !== 10'd0) begin n_fail++; $display("FAIL wrap_nl_cursor: got %0d want 0", cursor); end
  endtask

  task automatic test_clear_priority();
    send_byte(8'h51);
    act_q.delete(); exp_q.delete();
    clear = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h51;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL clr_ready_at_req: got %b want 0", bus.in_ready); end
    @(posedge clk); #1;
    clear = 1'b0;
    for (int i = 0; i < 640; i++) begin
      @(negedge clk);
      n_checks += 5;
      if (bus.we !== 1'b1) begin n_fail++; $display("FAIL clr_we[%0d]: got %b want 1", i, bus.we); end
      if (bus.address !== 32'(4 * i)) begin n_fail++; $display("FAIL clr_addr[%0d]: got %h want %h", i, bus.address, 32'(4 * i)); end
      if (bus.data_in !== 8'h20) begin n_fail++; $display("FAIL clr_data[%0d]: got %h want 20", i, bus.data_in); end
      if (busy !== 1'b1) begin n_fail++; $display("FAIL clr_busy[%0d]: got %b want 1", i, busy); end
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL clr_ready[%0d]: got %b want 0", i, bus.in_ready); end
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_checks += 5;
    if (bus.we !== 1'b0) begin n_fail++; $display("FAIL clr_end_we: got %b want 0", bus.we); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_end_busy: got %b want 0", busy); end
    if (cursor !== 10'd0) begin n_fail++; $display("FAIL clr_end_cursor: got %0d want 0", cursor); end
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL clr_end_ready: got %b want 1", bus.in_ready); end
    if (act_q.size() != 640) begin n_fail++; $display("FAIL clr_write_count: got %0d want 640", act_q.size()); end
    @(posedge clk); #1;
    act_q.delete(); exp_q.delete(); mcur = 0;
  endtask

  task automatic test_clear_during_write();
    logic [39:0] a, e;
    int nb = 0;
    send_byte(8'h41);
    act_q.delete(); exp_q.delete();
    bus.in_valid = 1'b1; bus.in_data = 8'h4D;
    for (int n = 0; n < 100 && bus.in_ready !== 1'b1; n++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    clear = 1'b1;
    model_apply(8'h4D);
    for (int i = 0; i < 640; i++) exp_q.push_back({32'(4 * i), 8'h20});
    mcur = 0;
    @(posedge clk); #1;
    clear = 1'b0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (busy === 1'b1) nb++;
      @(posedge clk); #1;
      clear = (i == 300);
    end
    clear = 1'b0;
    n_checks += 3;
    if (nb != 640) begin n_fail++; $display("FAIL cdw_busy_cycles: got %0d want 640", nb); end
    if (cursor !== 10'd0) begin n_fail++; $display("FAIL cdw_cursor: got %0d want 0", cursor); end
    if (act_q.size() != exp_q.size()) begin n_fail++; $display("FAIL cdw_count: got %0d want %0d", act_q.size(), exp_q.size()); end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front(); n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL cdw_write: got %h/%h want %h/%h", a[39:8], a[7:0], e[39:8], e[7:0]); end
    end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_sweep();
    send_byte(8'h41);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    for (int i = 0; i <= 100; i++) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks += 4;
    if (bus.we !== 1'b0) begin n_fail++; $display("FAIL rms_we: got %b want 0", bus.we); end
    if (cursor !== 10'd0) begin n_fail++; $display("FAIL rms_cursor: got %0d want 0", cursor); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rms_busy: got %b want 0", busy); end
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rms_ready: got %b want 0", bus.in_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks += 2;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rms_ready_after: got %b want 1", bus.in_ready); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rms_no_resume: got busy %b want 0", busy); end
    @(posedge clk); #1;
    act_q.delete(); exp_q.delete(); mcur = 0;
    send_byte(8'h41);
    n_checks++;
    if (act_q.size() != 1 || act_q[0] !== {32'h000, 8'h41}) begin n_fail++; $display("FAIL rms_first_write: got %0d writes, want one 0x41 at 0x000", act_q.size()); end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    logic [39:0] a, e;
    logic [7:0] b;
    int r;
    apply_reset();
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 99);
      if (r < 50)      b = 8'($urandom_range(32, 126));
      else if (r < 65) b = 8'h0A;
      else if (r < 80) b = 8'h08;
      else             b = 8'($urandom_range(0, 255));
      send_byte(b);
      n_checks += 2;
      if (cursor !== 10'(mcur)) begin n_fail++; $display("FAIL rnd_cursor[%0d] byte %h: got %0d want %0d", k, b, cursor, mcur); end
      if (act_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd_count[%0d] byte %h: got %0d want %0d", k, b, act_q.size(), exp_q.size()); end
      while (act_q.size() > 0 && exp_q.size() > 0) begin
        a = act_q.pop_front(); e = exp_q.pop_front(); n_checks++;
        if (a !== e) begin n_fail++; $display("FAIL rnd_write[%0d]: got %h/%h want %h/%h", k, a[39:8], a[7:0], e[39:8], e[7:0]); end
      end
      act_q.delete(); exp_q.delete();
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; mcur = 0;
    test_reset();
    test_basic();
    test_newline();
    test_backspace();
    test_wrap();
    test_clear_priority();
    test_clear_during_write();
    test_reset_mid_sweep();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/char_stream_writer.md
CHAR_STREAM_WRITER -- requirements
Module: char_stream_writer

Interface
REQ-001 Parameters SHALL be: COLS, default 80, characters per text line; ROWS, default 8, number of text lines; DEPTH, fixed at COLS*ROWS = 640, character cells in the downstream data memory.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  a character byte is offered on in_data.
REQ-005 in_data  input  8  offered character byte.
REQ-006 in_ready  output  1  the block accepts in_data this cycle.
REQ-007 clear  input  1  single-cycle request to blank the whole screen.
REQ-008 we  output  1  write strobe to the data memory.
REQ-009 address  output  32  data-memory byte address; cell i SHALL be driven as 4*i, bits [31:12] SHALL be 0.
REQ-010 data_in  output  8  byte written to the data memory.
REQ-011 cursor  output  10  index (0..DEPTH-1) of the next cell to be written.
REQ-012 busy  output  1  a clear sweep is in progress.

Function
REQ-013 The FSM SHALL have three states: IDLE, WRITE and CLEAR.
REQ-014 A transfer SHALL occur on a rising edge when in_valid=1 and in_ready=1; in_ready SHALL be 1 only in IDLE with clear=0.
REQ-015 we, address and data_in SHALL be registered outputs; we SHALL be 1 only in WRITE and CLEAR.
REQ-016 Printable byte (0x20..0x7E) accepted in IDLE: next cycle SHALL be WRITE with we=1, address=4*cursor, data_in=byte; cursor SHALL advance by 1 at the end of WRITE; the FSM SHALL then return to IDLE (throughput 1 byte per 2 cycles).
REQ-017 Cursor advance from DEPTH-1 SHALL wrap to 0.
REQ-018 Newline 0x0A accepted: no write; at the same edge cursor SHALL become the first cell of the next line (cursor - cursor mod COLS + COLS), wrapping to 0 from the last line; the FSM SHALL stay in IDLE.
REQ-019 Backspace 0x08 accepted with cursor>0: cursor SHALL decrement by 1, then a WRITE cycle SHALL write 0x20 at the new cursor; cursor SHALL NOT advance afterwards.
REQ-020 Backspace with cursor=0: SHALL be consumed with no write and cursor unchanged.
REQ-021 Any other byte (0x00..0x1F except 0x08/0x0A, and 0x7F..0xFF) SHALL be consumed and dropped with no write.
REQ-022 clear=1 in IDLE SHALL enter CLEAR at the next edge, and SHALL take priority over a simultaneous in_valid, which is not accepted.
REQ-023 clear=1 in WRITE SHALL complete the pending write, then enter CLEAR.
REQ-024 clear=1 during CLEAR SHALL be ignored.
REQ-025 CLEAR: exactly DEPTH consecutive cycles with we=1, data_in=0x20, address 0, 4, ..., 4*(DEPTH-1); busy=1 throughout; cursor SHALL be 0 on return to IDLE.
REQ-026 No data-memory read path SHALL exist; the block is write-only toward the memory.

Reset
REQ-027 While rst_n=0: state=IDLE, we=0, address=0, data_in=0, cursor=0, busy=0, in_ready=0.
REQ-028 in_ready SHALL first be 1 in the cycle after the first rising edge with rst_n=1.
REQ-029 Reset asserted mid-WRITE or mid-CLEAR SHALL abort immediately; we SHALL drop asynchronously; no sweep resumption.

Verification
REQ-030 Reset, send 'A' (0x41), 'B' (0x42) -> writes 0x41 at address 0x000 and 0x42 at 0x004; cursor=2; we high one cycle per byte.
REQ-031 Cursor at 5, send 0x0A -> no we pulse; cursor=80; next 'Z' (0x5A) is written at address 0x140.
REQ-032 Cursor at 639, send 'x' (0x78) -> write at address 0x9FC; cursor wraps to 0. Cursor at 600, send 0x0A -> cursor=0.
REQ-033 Cursor at 3, send 0x08 -> 0x20 written at address 0x008; cursor=2. Cursor at 0, send 0x08 -> no write; cursor=0.
REQ-034 Pulse clear together with in_valid=1 -> byte not accepted; 640 writes of 0x20 covering 0x000..0x9FC; busy high 640 cycles; cursor=0; in_ready=0 throughout.
REQ-035 Assert rst_n=0 at sweep cycle 100 -> we=0 immediately, cursor=0, busy=0; after release in_ready=1 and 'A' is written at address 0x000.
